// File: rtl/numpad_key_queue.sv
// Synchronises and debounces the numpad scanner output, turning each debounced
// key press into one event queued in a show-ahead FIFO with a valid/ready handshake.
module numpad_key_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] value,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_dropped
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       s_value_q, s_value_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             key_held_q, key_held_d;
    logic             key_dropped_q, key_dropped_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [3:0]       mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic push_ok;
    logic empty;
    logic full;

    always_comb begin
        sync1_d   = value;
        s_value_d = sync1_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_value_q[4]) begin
                    cand_d  = s_value_q[3:0];
                    cnt_d   = '0;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!s_value_q[4] || (s_value_q[3:0] != cand_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    push    = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s_value_q[4]) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (s_value_q[4]) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Rises together with the push; falls one edge after RELEASE_WAIT is left.
        key_held_d = push || (state_q == HELD) || (state_q == RELEASE_WAIT);
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = !empty && key_ready;
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        key_dropped_d = push && full && !pop;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            s_value_q     <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            cand_q        <= '0;
            key_held_q    <= 1'b0;
            key_dropped_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            sync1_q       <= sync1_d;
            s_value_q     <= s_value_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            key_held_q    <= key_held_d;
            key_dropped_q <= key_dropped_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cand_q;
        end
    end

    assign key_valid   = !empty;
    assign key_code    = empty ? 4'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign key_held    = key_held_q;
    assign key_dropped = key_dropped_q;

endmodule

// File: tb/tb_numpad_key_queue.sv
// Self-checking bench for numpad_key_queue: scenario tasks plus a scoreboard
// of expected key codes consumed whenever the handshake completes.
module tb_numpad_key_queue;

    logic       clock;
    logic       reset_n;
    logic [4:0] value;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       key_dropped;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    numpad_key_queue #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .value      (value),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_held   (key_held),
        .key_dropped(key_dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: every handshake must deliver the oldest expected code.
    always @(negedge clock) begin
        if (reset_n && key_valid && key_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got code %0d want no event", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    errors++;
                    $display("FAIL pop_code got %0d want %0d", key_code, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        value     = 5'h00;
        key_ready = 1'b0;
        #2;
        checks++;
        if ({key_valid, key_code, key_held, key_dropped} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000", {key_valid, key_code, key_held, key_dropped});
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({key_valid, key_held, key_dropped} !== 3'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want 000", {key_valid, key_held, key_dropped});
        end
    endtask

    task automatic test_clean_press();
        key_ready = 1'b0;
        value = 5'h15;
        exp_q.push_back(4'd5);
        repeat (6) tick();
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL clean_early got valid %b held %b want 0 0", key_valid, key_held);
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd5 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL clean_push got valid %b code %0d held %b want 1 5 1", key_valid, key_code, key_held);
        end
        repeat (13) tick();
        value = 5'h00;
        repeat (7) tick();
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL clean_held_before_fall got %b want 1", key_held);
        end
        tick();
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL clean_held_fall got %b want 0", key_held);
        end
        key_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (key_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clean_drain got valid %b pending %0d want 0 0", key_valid, exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int bad;
        key_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            value = ((i / 2) % 2 == 0) ? 5'h17 : 5'h00;
            tick();
            if (key_valid !== 1'b0 || key_held !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_quiet got %0d cycles with activity want 0", bad);
        end
        value = 5'h17;
        exp_q.push_back(4'd7);
        repeat (6) tick();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL bounce_early got valid %b want 0", key_valid);
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd7) begin
            errors++;
            $display("FAIL bounce_push got valid %b code %0d want 1 7", key_valid, key_code);
        end
        repeat (3) tick();
        value = 5'h00;
        repeat (10) tick();
        checks++;
        if (exp_q.size() != 0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_end got pending %0d held %b want 0 0", exp_q.size(), key_held);
        end
    endtask

    task automatic test_code_change();
        key_ready = 1'b1;
        value = 5'h13;
        repeat (3) tick();
        value = 5'h19;
        exp_q.push_back(4'd9);
        repeat (10) tick();
        value = 5'h00;
        repeat (10) tick();
        checks++;
        if (exp_q.size() != 0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL change_end got pending %0d valid %b want 0 0", exp_q.size(), key_valid);
        end
    endtask

    task automatic test_held_change();
        key_ready = 1'b1;
        value = 5'h12;
        exp_q.push_back(4'd2);
        repeat (7) tick();
        checks++;
        if (key_held !== 1'b1 || key_code !== 4'd2) begin
            errors++;
            $display("FAIL held_entry got held %b code %0d want 1 2", key_held, key_code);
        end
        value = 5'h1A;
        repeat (3) tick();
        value = 5'h00;
        repeat (2) tick();
        value = 5'h12;
        repeat (6) tick();
        checks++;
        if (key_held !== 1'b1 || key_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL held_no_extra got held %b valid %b pending %0d want 1 0 0", key_held, key_valid, exp_q.size());
        end
        value = 5'h00;
        repeat (10) tick();
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL held_release got %b want 0", key_held);
        end
        value = 5'h12;
        exp_q.push_back(4'd2);
        repeat (8) tick();
        value = 5'h00;
        repeat (10) tick();
        checks++;
        if (exp_q.size() != 0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_second got pending %0d valid %b want 0 0", exp_q.size(), key_valid);
        end
    endtask

    task automatic test_queue_full();
        key_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            logic [3:0] c;
            c = 4'(i);
            value = {1'b1, c};
            if (i <= 4) exp_q.push_back(c);
            repeat (6) tick();
            checks++;
            if (key_dropped !== 1'b0) begin
                errors++;
                $display("FAIL full_drop_early%0d got %b want 0", i, key_dropped);
            end
            tick();
            checks++;
            if (key_dropped !== (i == 5) || key_held !== 1'b1) begin
                errors++;
                $display("FAIL full_drop_edge%0d got drop %b held %b want %0d 1", i, key_dropped, key_held, (i == 5));
            end
            tick();
            checks++;
            if (key_dropped !== 1'b0 || key_code !== 4'd1) begin
                errors++;
                $display("FAIL full_after%0d got drop %b head %0d want 0 1", i, key_dropped, key_code);
            end
            value = 5'h00;
            repeat (10) tick();
        end
        key_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd4) begin
            errors++;
            $display("FAIL full_drain3 got valid %b code %0d want 1 4", key_valid, key_code);
        end
        tick();
        checks++;
        if (key_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain4 got valid %b pending %0d want 0 0", key_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        value = 5'h16;
        repeat (8) tick();
        value = 5'h00;
        repeat (10) tick();
        value = 5'h18;
        repeat (8) tick();
        value = 5'h00;
        repeat (10) tick();
        value = 5'h13;
        repeat (4) tick();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd6) begin
            errors++;
            $display("FAIL mid_prefill got valid %b code %0d want 1 6", key_valid, key_code);
        end
        #3;
        reset_n = 1'b0;
        value = 5'h00;
        #1;
        checks++;
        if ({key_valid, key_code, key_held, key_dropped} !== 7'b0) begin
            errors++;
            $display("FAIL mid_async got %b want 0000000", {key_valid, key_code, key_held, key_dropped});
        end
        #4;
        reset_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet got valid %b held %b want 0 0", key_valid, key_held);
        end
        key_ready = 1'b1;
        value = 5'h1E;
        exp_q.push_back(4'd14);
        repeat (6) tick();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_early got valid %b want 0", key_valid);
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd14) begin
            errors++;
            $display("FAIL mid_fresh got valid %b code %0d want 1 14", key_valid, key_code);
        end
        value = 5'h00;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_code_change();
        test_held_change();
        test_queue_full();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_empty got pending %0d valid %b want 0 0", exp_q.size(), key_valid);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/numpad_key_queue.md
# numpad_key_queue

Downstream stage of the numpad scanner. It synchronises the scanner's 5-bit `value` output, debounces press and release, and turns each debounced key press into exactly one event. Events are queued in a small FIFO and presented to the calculator core over a valid/ready handshake.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable cycles required to accept a press or a release; must be ≥ 2.
- `FIFO_DEPTH`, default 4: event queue depth; must be a power of 2, ≥ 2.
- `clock` in 1: single clock; all state is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `value` in 5: from the numpad scanner; `[4]` = a key is down, `[3:0]` = key code 0–15; asynchronous to `clock`.
- `key_code` out 4: code at the FIFO head; 0 when empty.
- `key_valid` out 1: FIFO not empty.
- `key_ready` in 1: consumer accepts the head this cycle.
- `key_held` out 1: debounced "a key is down" level.
- `key_dropped` out 1: one-cycle pulse when a debounced press is lost because the FIFO is full.

## Operation
- **Synchroniser**
  - Two-flop synchroniser on all 5 bits of `value`; `s_value` is the second flop.
  - The FSM uses only `s_value`.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. The FSM holds a counter `cnt` and a candidate code register `cand`.
- **IDLE**
  - If `s_value[4]`=1: `cand`←`s_value[3:0]`, `cnt`←0, go to PRESS_WAIT.
- **PRESS_WAIT**
  - If `s_value[4]`=0 or `s_value[3:0]`≠`cand`: go to IDLE. No event.
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1: push `cand`, go to HELD.
  - Else `cnt`++.
- **HELD**
  - `key_held`=1.
  - `s_value[4]`=1 with any code stays in HELD. A code change without a release generates no event.
  - `s_value[4]`=0: `cnt`←0, go to RELEASE_WAIT.
- **RELEASE_WAIT**
  - `key_held` stays 1.
  - `s_value[4]`=1: go to HELD. No new event.
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1: go to IDLE.
  - Else `cnt`++.
- **Counter:** `cnt` width is clog2(`DEBOUNCE_CYCLES`). It never wraps, because it is compared against the limit before incrementing.
- **FIFO**
  - Show-ahead: `key_code` = head entry, `key_valid` = !empty.
  - Pop when `key_valid` && `key_ready`. `key_ready` while empty is ignored.
  - A push is accepted if not full, or if a pop happens in the same cycle.
  - Push while full with no pop: the event is discarded, `key_dropped`=1 for one cycle, and the FIFO is unchanged.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits; full/empty is decided by the MSB comparison. Wrap-around is natural.
  - Order is strictly first in, first out.

## Timing
- **Reset (`reset_n`=0):** asynchronously forces the following; no event is produced from a press that was in progress at reset.
  - `key_valid`=0, `key_code`=0, `key_held`=0, `key_dropped`=0.
  - FIFO empty, state IDLE, `cnt`=0, `cand`=0, synchroniser flops 0.
- **Press latency:** edge 0 is the first edge that samples a pressed `value` with code C, held stable.
  - Edge 2: the FSM enters PRESS_WAIT.
  - Edge 2+`DEBOUNCE_CYCLES`: push. `key_valid`=1, `key_code`=C, and `key_held`=1 after that edge.
- **Release latency:** `key_held` falls `DEBOUNCE_CYCLES`+3 edges after the first edge that samples a released `value`, if the release stays stable.
- **Pop:** the handshake completes on an edge where `key_valid`&&`key_ready`. The next entry (or empty) is visible after that edge.
- **Simultaneous push and pop on an empty FIFO:** a pop cannot occur because `key_valid`=0, so the push lands normally.
- **Throughput:** at most one push and one pop per cycle.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `FIFO_DEPTH`=4.
- **Clean press:** `value`=5'h15 for 20 cycles, then 5'h00, `key_ready`=0 → `key_valid` rises after edge 6 with `key_code`=5. `key_held` =1 from edge 6 and falls 7 edges after the release. Exactly one event.
- **Bounce:** `value` toggles 5'h17/5'h00 every 2 cycles for 12 cycles, then 5'h17 stable for 10 cycles → no event during toggling. One event with code 7, 6 edges after the stable start.
- **Code change mid-debounce:** 5'h13 for 3 cycles, then 5'h19 stable for 10 cycles → a single event with code 9. Code 3 never appears.
- **Held code change and release bounce:** hold 5'h12 to HELD, switch to 5'h1A, drop to 5'h00 for 2 cycles, return to 5'h12 → one event only (code 2). Then a release of ≥7 cycles followed by a press of 5'h12 → a second event with code 2.
- **Queue full:** `key_ready`=0, five debounced presses with codes 1, 2, 3, 4, 5 → `key_dropped` pulses once, on the edge the code-5 push would occur. Then `key_ready`=1 → codes 1, 2, 3, 4 on consecutive cycles, then `key_valid`=0.
- **Reset mid-operation:** FIFO holding 2 entries and FSM in PRESS_WAIT, pulse `reset_n` low for a half cycle → all outputs 0 immediately. After release, no event until a fresh stable press.
